// File: rtl/inert_integ_p.sv
// Yaw-rate gyro offset calibration followed by deadbanded heading integration.
// The heading wraps modulo 2^HEAD_W, and a rdy strobe marks each integrated sample.
module inert_integ_p #(
  parameter int RATE_W    = 16,
  parameter int HEAD_W    = 12,
  parameter int FRAC_BITS = 11,
  parameter int CAL_LOG2  = 10,
  parameter int DEADBAND  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     strt_cal,
  input  logic                     vld,
  input  logic signed [RATE_W-1:0] rate,
  input  logic                     moving,
  output logic                     cal_done,
  output logic [HEAD_W-1:0]        heading,
  output logic                     rdy,
  output logic signed [RATE_W-1:0] offset
);

  localparam int ACC_W = HEAD_W + FRAC_BITS;
  localparam int SUM_W = RATE_W + CAL_LOG2;
  localparam logic [CAL_LOG2-1:0] CNT_LAST = '1;
  localparam logic signed [RATE_W:0] DB_POS = (RATE_W+1)'(DEADBAND);
  localparam logic signed [RATE_W:0] DB_NEG = -DB_POS;

  typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

  state_t                     state_q, state_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic signed [SUM_W-1:0]    sum_q, sum_d, sum_nxt;
  logic [CAL_LOG2-1:0]        cnt_q, cnt_d;
  logic signed [RATE_W-1:0]   off_q, off_d;
  logic                       cal_done_q, cal_done_d;
  logic                       rdy_q, rdy_d;
  logic signed [RATE_W:0]     corr, corr_db;

  assign sum_nxt = sum_q + SUM_W'(rate);

  // One extra bit means rate - offset can never overflow.
  assign corr    = (RATE_W+1)'(rate) - (RATE_W+1)'(off_q);
  assign corr_db = (!moving || (corr <= DB_POS && corr >= DB_NEG)) ? '0 : corr;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    cal_done_d = 1'b0;
    rdy_d      = 1'b0;
    if (strt_cal) begin
      // A restart wins over a coincident sample, which is dropped.
      state_d = CAL;
      sum_d   = '0;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (vld) begin
      case (state_q)
        CAL: begin
          sum_d = sum_nxt;
          cnt_d = cnt_q + CAL_LOG2'(1);
          if (cnt_q == CNT_LAST) begin
            off_d      = RATE_W'(sum_nxt >>> CAL_LOG2);
            state_d    = RUN;
            acc_d      = '0;
            sum_d      = '0;
            cnt_d      = '0;
            cal_done_d = 1'b1;
          end
        end
        RUN: begin
          acc_d = acc_q + ACC_W'(corr_db);
          rdy_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      off_q      <= '0;
      cal_done_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      cal_done_q <= cal_done_d;
      rdy_q      <= rdy_d;
    end
  end

  assign heading  = acc_q[ACC_W-1:FRAC_BITS];
  assign cal_done = cal_done_q;
  assign rdy      = rdy_q;
  assign offset   = off_q;

endmodule

// File: tb/tb_inert_integ_p.sv
// Randomised and directed bench for inert_integ_p, with an 8-sample calibration.
// Every cycle it compares the outputs against an arithmetic model of heading and offset.
module tb_inert_integ_p;
  localparam int NCAL = 8;
  localparam longint MOD = 64'sd1 <<< 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, strt_cal, vld, moving;
  logic signed [15:0] rate;
  logic cal_done, rdy;
  logic [11:0] heading;
  logic signed [15:0] offset;

  inert_integ_p #(.RATE_W(16), .HEAD_W(12), .FRAC_BITS(11), .CAL_LOG2(3), .DEADBAND(4)) dut (
    .clk(clk), .rst(rst), .strt_cal(strt_cal), .vld(vld), .rate(rate), .moving(moving),
    .cal_done(cal_done), .heading(heading), .rdy(rdy), .offset(offset)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_rdy = 0;
  int n_cal_done = 0;

  // Reference model: 0 = idle, 1 = calibrating, 2 = running.
  int     m_mode = 0;
  int     m_cnt = 0;
  longint m_sum = 0;
  longint m_off = 0;
  longint m_acc = 0;
  bit     m_rdy = 0;
  bit     m_cal_done = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r_rst, input bit s, input bit v, input int r, input bit mv);
    longint c;
    if (r_rst) begin
      m_mode = 0; m_cnt = 0; m_sum = 0; m_off = 0; m_acc = 0; m_rdy = 0; m_cal_done = 0;
    end else begin
      m_rdy = 0;
      m_cal_done = 0;
      if (s) begin
        m_mode = 1; m_sum = 0; m_cnt = 0; m_acc = 0;
      end else if (v && m_mode == 1) begin
        m_sum += r;
        m_cnt++;
        if (m_cnt == NCAL) begin
          m_off = (m_sum - (((m_sum % NCAL) + NCAL) % NCAL)) / NCAL;
          m_mode = 2; m_acc = 0; m_cnt = 0; m_sum = 0; m_cal_done = 1;
        end
      end else if (v && m_mode == 2) begin
        c = longint'(r) - m_off;
        if (!mv || (c <= 4 && c >= -4)) c = 0;
        m_acc = (((m_acc + c) % MOD) + MOD) % MOD;
        m_rdy = 1;
      end
    end
  endtask

  task automatic step(input bit r_rst, input bit s, input bit v, input int r, input bit mv);
    rst = r_rst; strt_cal = s; vld = v; rate = 16'(r); moving = mv;
    @(posedge clk);
    model(r_rst, s, v, int'(rate), mv);
    #1;
    chk("rdy", rdy, m_rdy);
    chk("cal_done", cal_done, m_cal_done);
    chk("heading", heading, m_acc >>> 11);
    chk("offset", offset, m_off);
    n_rdy += int'(rdy);
    n_cal_done += int'(cal_done);
  endtask

  task automatic samples(input int n, input int r, input bit mv);
    for (int i = 0; i < n; i++) step(0, 0, 1, r, mv);
  endtask

  task automatic calibrate(input int r);
    step(0, 1, 0, 0, 1);
    samples(NCAL, r, 1);
  endtask

  int base;

  initial begin
    // Reset, then a sample while idle must be ignored.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    base = n_rdy;
    step(0, 0, 1, 500, 1);
    step(0, 0, 0, 0, 1);
    chk("idle_rdy_cnt", n_rdy - base, 0);
    chk("idle_heading", heading, 0);

    calibrate(100);
    chk("cal_off_100", offset, 100);
    step(0, 0, 0, 0, 1);
    chk("cal_done_once", n_cal_done, 1);

    step(0, 1, 0, 0, 1);
    samples(7, -3, 1);
    samples(1, -4, 1);
    chk("cal_off_floor", offset, -4);

    calibrate(0);
    base = n_rdy;
    samples(10, 4, 1);
    chk("deadband_head", heading, 0);
    chk("deadband_rdy", n_rdy - base, 10);
    samples(5, 2048, 1);
    chk("int_head5", heading, 5);

    calibrate(0);
    samples(410, 5, 1);
    chk("frac_head1", heading, 1);

    calibrate(0);
    samples(1, -2048, 1);
    chk("wrap_down", heading, 12'hFFF);
    samples(1, 4096, 1);
    chk("wrap_up", heading, 12'h001);
    base = n_rdy;
    samples(1, 2048, 0);
    chk("hold_head", heading, 12'h001);
    chk("hold_rdy", n_rdy - base, 1);

    // A restart colliding with a sample drops the sample.
    step(0, 1, 1, 2048, 1);
    chk("collide_head", heading, 0);
    samples(NCAL, 7, 1);
    chk("collide_off", offset, 7);

    // A reset part-way through calibration.
    base = n_cal_done;
    step(0, 1, 0, 0, 1);
    samples(5, 50, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_off", offset, 0);
    samples(5, 50, 1);
    chk("rst_no_cal_done", n_cal_done - base, 0);

    calibrate(0);
    base = n_rdy;
    samples(16, 2048, 1);
    chk("thru_head", heading, 16);
    chk("thru_rdy", n_rdy - base, 16);

    // Random traffic, with occasional restarts and resets.
    for (int i = 0; i < 3000; i++) begin
      int p;
      int r;
      p = int'($urandom_range(0, 999));
      if ($urandom_range(0, 9) == 0) r = int'($urandom_range(0, 65535)) - 32768;
      else r = int'($urandom_range(0, 8000)) - 4000;
      step(p < 3, p >= 3 && p < 15, $urandom_range(0, 9) < 6, r, $urandom_range(0, 4) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/inert_integ_p.md
Name: inert_integ_p

Overview:
- Parametrised yaw-rate calibration and heading integrator; successor to the fixed-width integrator inside the inertial interface.
- Consumes signed yaw-rate samples from an upstream SPI/gyro reader through a valid strobe.
- Calibrates gyro offset by averaging 2^CAL_LOG2 samples, then integrates offset-corrected, deadbanded rate into a wrapping heading with configurable width and fraction bits.
- Produces a one-cycle rdy strobe per integrated sample for the navigation logic.

Parameters:
- RATE_W, 16: width of the signed rate sample.
- HEAD_W, 12: width of the unsigned heading output; a full circle is 2^HEAD_W counts.
- FRAC_BITS, 11: fractional bits kept in the accumulator below the heading LSB. Constraint: HEAD_W+FRAC_BITS >= RATE_W+1.
- CAL_LOG2, 10: log2 of the number of calibration samples.
- DEADBAND, 4: unsigned magnitude; corrected rates with |rate| <= DEADBAND are treated as 0.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- strt_cal  in  1  one-cycle pulse that starts or restarts calibration.
- vld  in  1  rate sample valid, one cycle per sample.
- rate  in  RATE_W  signed yaw rate; sampled only when vld=1.
- moving  in  1  1 = integrate; 0 = hold heading.
- cal_done  out  1  one-cycle pulse when calibration completes.
- heading  out  HEAD_W  accumulator[HEAD_W+FRAC_BITS-1:FRAC_BITS].
- rdy  out  1  one-cycle pulse: heading updated for a RUN-state sample.
- offset  out  RATE_W  current signed offset estimate (debug/verification).

Behaviour:
- Reset and clocking: one clock (clk); reset (rst) is synchronous and active-high. rst=1 at a rising edge sets state=IDLE, cal_done=0, rdy=0, heading=0, offset=0, accumulator=0, cal sum=0, sample count=0. rst has priority over all inputs, including mid-CAL and mid-RUN.
- States: IDLE, CAL, RUN.
- IDLE: vld ignored, rdy=0. strt_cal -> CAL.
- Any state with strt_cal=1 -> CAL. Clear cal sum, sample count and accumulator (heading reads 0 next cycle); cal_done=0. strt_cal beats vld in the same cycle: that sample is discarded.
- CAL:
  - Each vld adds sign-extended rate to the cal sum (RATE_W+CAL_LOG2 bits, no overflow possible) and increments the count.
  - On the edge accepting sample number 2^CAL_LOG2: offset <= cal sum >>> CAL_LOG2 (arithmetic shift, i.e. floor), state -> RUN, accumulator <= 0.
  - cal_done=1 in the following cycle only.
  - rdy=0 throughout CAL.
- RUN, on each vld:
  - corr = rate - offset, computed in RATE_W+1 signed bits (no saturation).
  - If |corr| <= DEADBAND or moving=0, corr = 0.
  - accumulator <= accumulator + sign-extend(corr), modulo 2^(HEAD_W+FRAC_BITS). Wrap-around in both directions is required; no saturation.
  - rdy=1 in the cycle after the accepting edge, for exactly one cycle, even when corr was forced to 0.
  - heading is valid whenever rdy=1.
  - Back-to-back vld on consecutive cycles must be accepted: one rdy per vld, latency 1.
- RUN without vld: accumulator holds, rdy=0.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst 3 cycles, then pulse vld with rate=500 in IDLE -> heading=0, rdy never asserts, cal_done=0, offset=0.
- Calibration (CAL_LOG2=3): strt_cal, then 8 vld with rate=100 -> cal_done high exactly one cycle after the 8th vld edge, offset=100. Repeat with rate=-3 plus one sample of -4 (sum -25) -> offset=-4 (floor).
- Deadband/integration (offset 0, FRAC_BITS=11, DEADBAND=4):
  - rate=4 for 10 samples -> heading 0, 10 rdy pulses.
  - rate=2048 for 5 samples -> heading 5.
  - rate=5 for 410 samples -> heading 1 (2050/2048).
- Wrap and moving:
  - From heading 0, one sample rate=-2048 -> heading 0xFFF.
  - From 0xFFF, rate=+4096 -> heading 0x001.
  - moving=0 with rate=2048 -> heading unchanged, rdy still pulses.
- Restart and collision:
  - strt_cal with vld in the same cycle mid-RUN -> sample discarded, heading 0 next cycle, state CAL, new offset computed from the next 8 samples only.
  - rst asserted after 5 of 8 cal samples -> all outputs 0, cal_done never pulses.
- Throughput: 16 consecutive vld cycles in RUN with rate=2048 -> 16 rdy pulses, heading=16, no dropped samples.
